// File: rtl/xmem_stream_loader.sv
// xmem_stream_loader
//   Bus master in front of an xmem data port. It moves a strided block of
//   words in one of two directions:
//     - write mode (dir=0): input stream -> xmem
//     - read mode  (dir=1): xmem -> output stream
//   Each xmem transaction is one valid/ready handshake. FETCH and PUSH always
//   sit between two REQ cycles, so m_valid_o drops for at least one cycle
//   between transactions, as the xmem ready-pulse protocol requires.
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   start_i, dir_i, base_addr_i,
//   incr_i, len_i                   transfer configuration, latched on start_i
//   busy_o, done_o                  status; done_o is a 1-cycle pulse
//   s_valid_i/s_data_i/s_ready_o    input stream (write mode)
//   o_valid_o/o_data_o/o_ready_i    output stream (read mode)
//   m_valid_o/m_addr_o/m_wdata_o/
//   m_wstrb_o/m_ready_i/m_rdata_i   xmem bus
module xmem_stream_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                dir_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [ADDR_W-1:0]   incr_i,
  input  logic [LEN_W-1:0]    len_i,
  output logic                busy_o,
  output logic                done_o,
  input  logic                s_valid_i,
  input  logic [DATA_W-1:0]   s_data_i,
  output logic                s_ready_o,
  output logic                o_valid_o,
  output logic [DATA_W-1:0]   o_data_o,
  input  logic                o_ready_i,
  output logic                m_valid_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  input  logic                m_ready_i,
  input  logic [DATA_W-1:0]   m_rdata_i
);

  typedef enum logic [2:0] {IDLE, FETCH, REQ, PUSH, DONE} state_e;

  state_e                state_q, state_d;
  logic                  dir_q, dir_d;
  logic [ADDR_W-1:0]     incr_q, incr_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     odata_q, odata_d;
  logic [LEN_W-1:0]      cnt_inc;

  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    incr_d  = incr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    odata_d = odata_q;
    case (state_q)
      IDLE: if (start_i) begin
        dir_d  = dir_i;
        incr_d = incr_i;
        len_d  = len_i;
        addr_d = base_addr_i;
        cnt_d  = '0;
        if (len_i == '0) state_d = DONE;
        else             state_d = dir_i ? REQ : FETCH;
      end
      FETCH: if (s_valid_i) begin
        wdata_d = s_data_i;
        state_d = REQ;
      end
      REQ: if (m_ready_i) begin
        cnt_d  = cnt_inc;
        addr_d = addr_q + incr_q;  // wraps mod 2^ADDR_W; incr may be negative
        if (dir_q) begin
          odata_d = m_rdata_i;
          state_d = PUSH;
        end else begin
          state_d = (cnt_inc == len_q) ? DONE : FETCH;
        end
      end
      // cnt was already advanced on the handshake that fetched this word
      PUSH: if (o_ready_i) state_d = (cnt_q == len_q) ? DONE : REQ;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are true
  // registers that line up with state_q.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      incr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      odata_q   <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      s_ready_o <= 1'b0;
      o_valid_o <= 1'b0;
      m_valid_o <= 1'b0;
      m_wstrb_o <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      incr_q    <= incr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      odata_q   <= odata_d;
      busy_o    <= (state_d != IDLE);
      done_o    <= (state_d == DONE);
      s_ready_o <= (state_d == FETCH);
      o_valid_o <= (state_d == PUSH);
      m_valid_o <= (state_d == REQ);
      m_wstrb_o <= (state_d == REQ && !dir_d) ? {(DATA_W/8){1'b1}} : '0;
    end
  end

  assign m_addr_o  = addr_q;
  assign m_wdata_o = wdata_q;
  assign o_data_o  = odata_q;

endmodule

// File: tb/tb_xmem_stream_loader.sv
// Scoreboard bench for xmem_stream_loader: expected xmem transactions and
// output-stream words are queued as stimulus is planned and checked as the
// DUT produces them. A small xmem model answers every request with ready
// three cycles after valid.
module tb_xmem_stream_loader;
  localparam int DW = 32, AW = 10, LW = 11;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, dir = 1'b0;
  logic [AW-1:0] base = '0, incr = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, s_ready, o_valid, m_valid;
  logic          s_valid = 1'b0, o_ready = 1'b1, m_ready = 1'b0;
  logic [DW-1:0] s_data = '0, o_data, m_wdata, m_rdata = '0;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_wstrb;

  xmem_stream_loader #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .dir_i(dir),
    .base_addr_i(base), .incr_i(incr), .len_i(len),
    .busy_o(busy), .done_o(done),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
    .o_valid_o(o_valid), .o_data_o(o_data), .o_ready_i(o_ready),
    .m_valid_o(m_valid), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
    .m_wstrb_o(m_wstrb), .m_ready_i(m_ready), .m_rdata_i(m_rdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:1023];
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_wdata [$], exp_odata [$], src_q [$];
  int nvec = 0, nerr = 0;
  int done_cnt = 0, act_cnt = 0, mhs_cnt = 0;
  logic cur_dir = 1'b0;
  bit gap_pend = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // xmem model: ready pulse 3 cycles after valid rises
  initial begin
    int lat;
    lat = 0;
    forever begin
      @(posedge clk); #1;
      m_ready = 1'b0;
      if (m_valid) begin
        lat++;
        if (lat == 3) begin
          m_ready = 1'b1;
          lat = 0;
          if (m_wstrb != 4'h0) mem[m_addr] = m_wdata;
          else                 m_rdata = mem[m_addr];
        end
      end else lat = 0;
    end
  end

  // input stream source fed from src_q
  initial begin
    bit hs;
    forever begin
      @(negedge clk);
      hs = s_valid && s_ready;
      @(posedge clk); #1;
      if (hs && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        s_valid = 1'b1;
        s_data  = src_q[0];
      end else s_valid = 1'b0;
    end
  end

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (gap_pend) begin
        chk("m_gap", m_valid, 0);
        gap_pend = 1'b0;
      end
      if (done) done_cnt++;
      if (m_valid || s_ready || o_valid) act_cnt++;
      if (m_valid && m_ready) begin
        mhs_cnt++;
        gap_pend = 1'b1;
        if (exp_addr.size() == 0) chk("m_extra", 1, 0);
        else chk("m_addr", m_addr, exp_addr.pop_front());
        chk("m_wstrb", m_wstrb, cur_dir ? 64'h0 : 64'hF);
        if (!cur_dir) begin
          if (exp_wdata.size() == 0) chk("w_extra", 1, 0);
          else chk("m_wdata", m_wdata, exp_wdata.pop_front());
        end
      end
      if (o_valid && o_ready) begin
        if (exp_odata.size() == 0) chk("o_extra", 1, 0);
        else chk("o_data", o_data, exp_odata.pop_front());
      end
    end
  end

  // Start pulse; inputs are scrambled afterwards to prove they were latched.
  task automatic do_start(input logic d, input logic [AW-1:0] b, input logic [AW-1:0] i,
                          input logic [LW-1:0] l);
    @(posedge clk); #1;
    start = 1'b1; dir = d; base = b; incr = i; len = l;
    @(posedge clk); #1;
    start = 1'b0; dir = ~d; base = ~b; incr = ~i; len = '0;
  endtask

  task automatic wait_done(input int d0, input int maxc, input string tag);
    int c;
    c = 0;
    while (done_cnt == d0 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_done"}, done_cnt != d0, 1);
  endtask

  task automatic post_chk(input int d0, input string tag);
    @(negedge clk); @(negedge clk);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ndone"}, done_cnt - d0, 1);
    chk({tag, "_drain"}, exp_addr.size() + exp_wdata.size() + exp_odata.size(), 0);
  endtask

  task automatic xfer(input logic d, input logic [AW-1:0] b, input logic [AW-1:0] i,
                      input logic [LW-1:0] l, input string tag);
    int d0;
    cur_dir = d;
    d0 = done_cnt;
    do_start(d, b, i, l);
    wait_done(d0, 300, tag);
    post_chk(d0, tag);
  endtask

  task automatic exp_w(input logic [AW-1:0] a, input logic [DW-1:0] v);
    exp_addr.push_back(a);
    exp_wdata.push_back(v);
    src_q.push_back(v);
  endtask

  task automatic exp_r(input logic [AW-1:0] a, input logic [DW-1:0] v);
    mem[a] = v;
    exp_addr.push_back(a);
    exp_odata.push_back(v);
  endtask

  initial begin
    int d0, a0, h0, c;
    for (int k = 0; k < 1024; k++) mem[k] = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ctl", {busy, done, s_ready, o_valid, m_valid, m_wstrb}, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_wdata", m_wdata, 0);
    chk("rst_odata", o_data, 0);
    @(posedge clk); #1 rst = 1'b0;

    // basic write
    for (int k = 0; k < 4; k++) exp_w(AW'(16 + k), DW'(32'hA0 + k));
    xfer(1'b0, 10'h010, 10'h001, 11'd4, "wr4");

    // strided read
    exp_r(10'h020, 32'h11);
    exp_r(10'h022, 32'h22);
    exp_r(10'h024, 32'h33);
    xfer(1'b1, 10'h020, 10'h002, 11'd3, "rd3");

    // address wrap
    exp_w(10'h3FF, 32'h5A5A0001);
    exp_w(10'h000, 32'h5A5A0002);
    xfer(1'b0, 10'h3FF, 10'h001, 11'd2, "wrap");

    // negative stride
    exp_w(10'h001, 32'hC0DE0001);
    exp_w(10'h000, 32'hC0DE0002);
    exp_w(10'h3FF, 32'hC0DE0003);
    xfer(1'b0, 10'h001, 10'h3FF, 11'd3, "neg");

    // len = 0
    d0 = done_cnt;
    a0 = act_cnt;
    do_start(1'b0, 10'h005, 10'h001, 11'd0);
    @(negedge clk);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 1);
    @(negedge clk);
    chk("len0_pulse", done, 0);
    repeat (3) @(negedge clk);
    chk("len0_act", act_cnt - a0, 0);
    chk("len0_ndone", done_cnt - d0, 1);

    // output backpressure, plus a start pulse while busy
    o_ready = 1'b0;
    exp_r(10'h030, 32'h55);
    exp_r(10'h031, 32'h66);
    cur_dir = 1'b1;
    d0 = done_cnt;
    do_start(1'b1, 10'h030, 10'h001, 11'd2);
    c = 0;
    while (!o_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("bp_ovalid", o_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_v", o_valid, 1);
      chk("bp_hold_d", o_data, 32'h55);
      chk("bp_no_req", m_valid, 0);
    end
    do_start(1'b0, 10'h200, 10'h001, 11'd5);
    o_ready = 1'b1;
    wait_done(d0, 300, "bp");
    post_chk(d0, "bp");
    repeat (3) @(negedge clk);
    chk("bp_idle", busy, 0);

    // reset in the middle of a write
    for (int k = 0; k < 8; k++) exp_w(AW'(10'h100 + k), DW'(32'hB0 + k));
    cur_dir = 1'b0;
    d0 = done_cnt;
    h0 = mhs_cnt;
    do_start(1'b0, 10'h100, 10'h001, 11'd8);
    c = 0;
    while (mhs_cnt - h0 < 3 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("mid_pre", mhs_cnt - h0 >= 3, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    exp_addr.delete();
    exp_wdata.delete();
    src_q.delete();
    @(negedge clk);
    chk("mid_ctl", {busy, done, s_ready, o_valid, m_valid, m_wstrb}, 0);
    chk("mid_addr", m_addr, 0);
    chk("mid_wdata", m_wdata, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_nodone", done_cnt - d0, 0);
    chk("mid_busy", busy, 0);

    // clean transfer after reset
    exp_w(10'h200, 32'hC0);
    exp_w(10'h201, 32'hC1);
    xfer(1'b0, 10'h200, 10'h001, 11'd2, "post");
    chk("post_mem0", mem[10'h200], 32'hC0);
    chk("post_mem1", mem[10'h201], 32'hC1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/xmem_stream_loader.md
Name: xmem_stream_loader

Overview:
- Bus-master stage directly upstream of an xmem data-bus port (wstrb/addr/wdata/valid/ready/rdata).
- Write mode: moves a block of words from an input stream into xmem at strided addresses.
- Read mode: reads a strided block out of xmem onto an output stream.
- Fills xmem before a run and drains results after it, without host CPU word-by-word access.

Parameters:
- DATA_W, 32, data word width; equals the xmem DATA_W.
- ADDR_W, 10, xmem address width.
- LEN_W, 11, transfer-length width; allows up to 2^ADDR_W words.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  1-cycle pulse; latches configuration and begins a transfer
- dir  input  1  0 = stream->mem (write), 1 = mem->stream (read)
- base_addr  input  ADDR_W  first xmem address
- incr  input  ADDR_W  address step per word (two's complement, wraps mod 2^ADDR_W)
- len  input  LEN_W  number of words
- busy  output  1  high from the cycle after start until done
- done  output  1  1-cycle pulse at end of transfer
- s_valid  input  1  input stream valid
- s_data  input  DATA_W  input stream data
- s_ready  output  1  input stream ready
- o_valid  output  1  output stream valid
- o_data  output  DATA_W  output stream data
- o_ready  input  1  output stream ready
- m_valid  output  1  to xmem valid
- m_addr  output  ADDR_W  to xmem addr
- m_wdata  output  DATA_W  to xmem wdata
- m_wstrb  output  DATA_W/8  to xmem wstrb
- m_ready  input  1  from xmem ready
- m_rdata  input  DATA_W  from xmem rdata

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high (rst).
- Reset values: all outputs 0. State = IDLE; counters and registers cleared.
- Reset mid-transfer aborts immediately: no done pulse; m_valid drops on the next edge.
- States: IDLE, FETCH, REQ, PUSH, DONE.
- Registered outputs:
  - busy = (state != IDLE).
  - s_ready = (state == FETCH).
  - m_valid = (state == REQ).
  - o_valid = (state == PUSH).
  - done = (state == DONE).
- IDLE: on start, latch dir, base_addr, incr and len; set cur_addr = base_addr and cnt = 0.
  - len == 0 -> DONE.
  - dir == 0 -> FETCH.
  - dir == 1 -> REQ.
  - start outside IDLE is ignored. Inputs changing after start have no effect.
- FETCH (write only): s_ready = 1. On s_valid, capture s_data into m_wdata and go to REQ.
- REQ:
  - m_valid = 1 and m_addr = cur_addr, held stable until m_ready is sampled high.
  - m_wstrb = all ones in write mode, 0 in read mode.
  - On m_ready:
    - cnt += 1; cur_addr = cur_addr + incr, truncated to ADDR_W.
    - Write mode: cnt == len -> DONE, else FETCH.
    - Read mode: capture m_rdata into o_data, go to PUSH.
  - m_valid is low in the cycle after the handshake.
  - m_valid is never high for two consecutive transactions without at least one low cycle (xmem ready-pulse protocol). FETCH and PUSH each last at least one cycle, which guarantees this gap.
- PUSH (read only): o_valid = 1 and o_data held until o_ready. On o_ready: cnt == len -> DONE, else REQ.
- DONE: done = 1 for exactly one cycle -> IDLE. busy falls in the same cycle as the transition to IDLE.
- Arbitrary m_ready latency; no timeout. xmem returns ready 3 cycles after valid on reads and writes; the throughput target is one word per 5 cycles under that latency with streams always ready/valid.
- m_ready while not in REQ is ignored.
- Stream backpressure may stall indefinitely.
- Address wrap: base 0x3FE, incr 1 gives 0x3FE, 0x3FF, 0x000, ...
- len counts up to 2^ADDR_W; cnt is LEN_W wide and is compared for equality.

Test Plan:
- Write, len=4, base=0x010, incr=1, s_data 0xA0..0xA3, xmem model with 3-cycle ready:
  - writes addr 0x010..0x013 with data 0xA0..0xA3 and wstrb=0xF;
  - done pulses once; busy low afterwards;
  - m_valid shows a low cycle between transactions.
- Read, len=3, base=0x020, incr=2, memory preloaded with 0x11/0x22/0x33 at 0x020/0x022/0x024:
  - o_data sequence 0x11, 0x22, 0x33; wstrb=0 throughout.
- Wrap and negative stride:
  - base=0x3FF, incr=1, len=2: addresses 0x3FF then 0x000.
  - base=0x001, incr=0x3FF (−1), len=3: addresses 0x001, 0x000, 0x3FF.
- len=0 start: done asserted 1 cycle after start; no m_valid, s_ready or o_valid activity.
- Backpressure, read len=2:
  - hold o_ready low 5 cycles: o_valid and o_data stay stable; no new m_valid until the word is accepted.
  - start pulsed while busy is ignored.
- Reset mid-transfer (write len=8, after 3 words): all outputs 0 on the next edge, no done pulse; a new transfer starts cleanly afterwards.
